// File: rtl/ma_packet_sender_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the MA packet sender.
package ma_packet_sender_pkg;

  localparam int MA_PACKET_SIZE    = 40;
  localparam int DATA_LENGTH       = 16;
  localparam int OTHER_DATA_LENGTH = 24;
  localparam int ADDR_LENGTH       = 10;

  // Handshake sequencer states
  typedef enum logic [1:0] {
    MATX_IDLE  = 2'd0,
    MATX_SETUP = 2'd1,
    MATX_REQ   = 2'd2,
    MATX_REL   = 2'd3
  } matx_state_e;

  // One buffered MA-bound transfer (58 bits)
  typedef struct packed {
    logic [DATA_LENGTH-1:0]    write_data;
    logic                      write_en;
    logic                      load_flg;
    logic [MA_PACKET_SIZE-1:0] packet;
  } matx_entry_t;

endpackage

// File: rtl/ma_tx_fifo.sv
// Small circular buffer of MA transfers; occupancy counter tells full from empty.
module ma_tx_fifo
  import ma_packet_sender_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CP,
  input  logic                   MR_N,
  input  logic                   i_push,
  input  matx_entry_t            i_data,
  input  logic                   i_pop,
  output matx_entry_t            o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  matx_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge CP) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push/pop balance
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_ready = (r_count < CW'(DEPTH));

endmodule

// File: rtl/ma_packet_sender.sv
// Clocked source for the MA stage's 4-phase bundled-data input handshake.
module ma_packet_sender
  import ma_packet_sender_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic                      CP,
  input  logic                      MR_N,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [MA_PACKET_SIZE-1:0] IN_PACKET,
  input  logic                      IN_LOAD_FLG,
  input  logic                      IN_WRITE_EN,
  input  logic [DATA_LENGTH-1:0]    IN_WRITE_DATA,
  output logic                      Send_out,
  input  logic                      Ack_in,
  output logic [MA_PACKET_SIZE-1:0] PACKET_OUT,
  output logic                      LOAD_FLG,
  output logic                      WRITE_EN,
  output logic [DATA_LENGTH-1:0]    WRITE_DATA,
  output logic [$clog2(DEPTH):0]    COUNT,
  output logic                      BUSY,
  output logic                      TIMEOUT_ERR
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(TIMEOUT + 1);

  matx_state_e            r_state, w_next;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;
  logic                   r_send;
  matx_entry_t            r_out;
  logic [SW-1:0]          r_stall;
  logic                   r_err;
  logic                   w_push, w_pop, w_send_set, w_send_clr, w_ready;
  matx_entry_t            w_in, w_head;
  logic [CW-1:0]          w_count;

  assign w_in.write_data = IN_WRITE_DATA;
  assign w_in.write_en   = IN_WRITE_EN;
  assign w_in.load_flg   = IN_LOAD_FLG;
  assign w_in.packet     = IN_PACKET;
  assign w_push          = IN_VALID && w_ready;

  ma_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CP      (CP),
    .MR_N    (MR_N),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_ready (w_ready)
  );

  // Ack_in is asynchronous to CP: resolve it through a plain flop chain
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) r_ack_sync <= '0;
    else       r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], Ack_in};
  end
  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // State register
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) r_state <= MATX_IDLE;
    else       r_state <= w_next;
  end

  // Next state; ack is only looked at once the request is actually up (REQ/REL)
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_send_set = 1'b0;
    w_send_clr = 1'b0;
    unique case (r_state)
      MATX_IDLE:  if (w_count != '0) begin w_pop = 1'b1; w_next = MATX_SETUP; end
      MATX_SETUP: begin w_send_set = 1'b1; w_next = MATX_REQ; end
      MATX_REQ:   if (w_ack_s) begin w_send_clr = 1'b1; w_next = MATX_REL; end
      MATX_REL:   if (!w_ack_s) w_next = MATX_IDLE;
      default:    w_next = MATX_IDLE;
    endcase
  end

  // Request flop and bundled data: data loads a full cycle before Send_out rises
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      r_send <= 1'b0;
      r_out  <= '0;
    end else begin
      if (w_send_set)      r_send <= 1'b1;
      else if (w_send_clr) r_send <= 1'b0;
      if (w_pop) r_out <= w_head;
    end
  end

  // Stall watchdog: saturating count of REQ cycles; flag is sticky until reset
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == MATX_SETUP) r_stall <= '0;
      else if (r_state == MATX_REQ && r_stall != SW'(TIMEOUT)) r_stall <= r_stall + SW'(1);
      if (r_state == MATX_REQ && r_stall >= SW'(TIMEOUT - 1)) r_err <= 1'b1;
    end
  end

  assign IN_READY    = w_ready;
  assign Send_out    = r_send;
  assign PACKET_OUT  = r_out.packet;
  assign LOAD_FLG    = r_out.load_flg;
  assign WRITE_EN    = r_out.write_en;
  assign WRITE_DATA  = r_out.write_data;
  assign COUNT       = w_count;
  assign BUSY        = (r_state != MATX_IDLE) || (w_count != '0);
  assign TIMEOUT_ERR = r_err;

endmodule

// File: tb/tb_ma_packet_sender.sv
// Bench for ma_packet_sender: scripted MA responder, delivery monitor, queue model.
module tb_ma_packet_sender;
  import ma_packet_sender_pkg::*;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int TMO   = 16;

  logic        CP = 1'b0, MR_N = 1'b1, IN_VALID = 1'b0;
  logic        IN_READY, IN_LOAD_FLG = 1'b0, IN_WRITE_EN = 1'b0;
  logic [39:0] IN_PACKET = '0;
  logic [15:0] IN_WRITE_DATA = '0;
  logic        Send_out, Ack_in = 1'b0;
  logic [39:0] PACKET_OUT;
  logic        LOAD_FLG, WRITE_EN;
  logic [15:0] WRITE_DATA;
  logic [2:0]  COUNT;
  logic        BUSY, TIMEOUT_ERR;

  int n_cmp = 0, n_err = 0, cyc = 0;
  bit auto_ack = 1'b0, man_ack = 1'b0, prev_send = 1'b0;
  int ack_delay = 0, ack_cnt = 0;

  typedef struct { matx_entry_t e; int cyc; } dlv_t;
  dlv_t got_q[$];

  ma_packet_sender #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .CP(CP), .MR_N(MR_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_PACKET(IN_PACKET), .IN_LOAD_FLG(IN_LOAD_FLG), .IN_WRITE_EN(IN_WRITE_EN),
    .IN_WRITE_DATA(IN_WRITE_DATA), .Send_out(Send_out), .Ack_in(Ack_in),
    .PACKET_OUT(PACKET_OUT), .LOAD_FLG(LOAD_FLG), .WRITE_EN(WRITE_EN),
    .WRITE_DATA(WRITE_DATA), .COUNT(COUNT), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CP = ~CP;
  always @(posedge CP) cyc <= cyc + 1;

  function automatic matx_entry_t cur_out();
    matx_entry_t o;
    o.packet = PACKET_OUT; o.load_flg = LOAD_FLG; o.write_en = WRITE_EN; o.write_data = WRITE_DATA;
    return o;
  endfunction

  function automatic matx_entry_t rnd_entry();
    matx_entry_t o;
    o.packet = 40'({$urandom(), $urandom()});
    o.load_flg = 1'($urandom()); o.write_en = 1'($urandom());
    o.write_data = 16'($urandom());
    return o;
  endfunction

  // MA responder: either follows man_ack, or acks ack_delay negedges after a request
  initial forever begin
    @(negedge CP);
    if (!auto_ack) begin Ack_in = man_ack; ack_cnt = 0; end
    else if (Send_out && !Ack_in) begin
      if (ack_cnt >= ack_delay) Ack_in = 1'b1; else ack_cnt++;
    end else if (!Send_out && Ack_in) begin Ack_in = 1'b0; ack_cnt = 0; end
  end

  // Record the bundled data and cycle of every request rise
  initial forever begin
    dlv_t d;
    @(negedge CP);
    if (Send_out && !prev_send) begin d.e = cur_out(); d.cyc = cyc; got_q.push_back(d); end
    prev_send = Send_out;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input matx_entry_t e, output bit acc);
    @(negedge CP);
    IN_VALID = 1'b1; IN_PACKET = e.packet; IN_LOAD_FLG = e.load_flg;
    IN_WRITE_EN = e.write_en; IN_WRITE_DATA = e.write_data;
    acc = IN_READY;
    @(posedge CP); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin @(posedge CP); #1; end
  endtask

  task automatic do_reset();
    auto_ack = 1'b0; man_ack = 1'b0;
    @(negedge CP); MR_N = 1'b0;
    @(posedge CP); @(negedge CP); MR_N = 1'b1;
    @(posedge CP); #1;
    got_q.delete();
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int t = 0;
    while (got_q.size() < n && t < budget) begin @(posedge CP); #1; t++; end
    n_cmp++;
    if (got_q.size() < n) begin n_err++; $display("FAIL %s: %0d deliveries, expected %0d", name, got_q.size(), n); end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (BUSY && t < budget) begin @(posedge CP); #1; t++; end
    n_cmp++;
    if (BUSY !== 1'b0) begin n_err++; $display("FAIL %s: BUSY=%b expected 0", name, BUSY); end
  endtask

  task automatic test_reset();
    matx_entry_t e; bit acc; int t;
    #1 MR_N = 1'b0; #2;
    n_cmp++;
    if ({Send_out, LOAD_FLG, WRITE_EN, BUSY, TIMEOUT_ERR, IN_READY} !== 6'b000001) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000001", {Send_out, LOAD_FLG, WRITE_EN, BUSY, TIMEOUT_ERR, IN_READY});
    end
    n_cmp++;
    if (PACKET_OUT !== '0 || WRITE_DATA !== '0 || COUNT !== '0) begin
      n_err++; $display("FAIL reset_data: pkt=%h wd=%h cnt=%0d expected 0", PACKET_OUT, WRITE_DATA, COUNT);
    end
    @(negedge CP); MR_N = 1'b1;
    repeat (2) begin e = rnd_entry(); push(e, acc); end
    t = 0;
    while (!Send_out && t < 10) begin @(posedge CP); #1; t++; end
    n_cmp++;
    if (Send_out !== 1'b1 || COUNT !== 3'd1) begin
      n_err++; $display("FAIL reset_prep: send=%b cnt=%0d expected 1/1", Send_out, COUNT);
    end
    @(negedge CP); #2; MR_N = 1'b0; #1;
    n_cmp++;
    if ({Send_out, LOAD_FLG, WRITE_EN, BUSY, IN_READY} !== 5'b00001 || PACKET_OUT !== '0 ||
        WRITE_DATA !== '0 || COUNT !== '0) begin
      n_err++; $display("FAIL reset_midhs: send=%b busy=%b rdy=%b cnt=%0d pkt=%h", Send_out, BUSY, IN_READY, COUNT, PACKET_OUT);
    end
    @(posedge CP); @(negedge CP); MR_N = 1'b1;
    @(posedge CP); #1;
    got_q.delete();
  endtask

  task automatic test_single_store();
    matx_entry_t e; bit acc; int k, fall; bit unstable;
    e.packet = 40'h00ABC_0123; e.load_flg = 1'b0; e.write_en = 1'b1; e.write_data = 16'hBEEF;
    auto_ack = 1'b1; ack_delay = 3;
    push(e, acc); k = cyc;
    n_cmp++;
    if (!acc || COUNT !== 3'd1 || Send_out !== 1'b0) begin
      n_err++; $display("FAIL store_push: acc=%b cnt=%0d send=%b expected 1/1/0", acc, COUNT, Send_out);
    end
    wait_to(k + 1);
    n_cmp++;
    if (cur_out() !== e || Send_out !== 1'b0 || COUNT !== 3'd0) begin
      n_err++; $display("FAIL store_load: out=%h send=%b cnt=%0d expected %h/0/0", cur_out(), Send_out, COUNT, e);
    end
    wait_to(k + 2);
    n_cmp++;
    if (Send_out !== 1'b1) begin n_err++; $display("FAIL store_send: Send_out=%b at k+2 expected 1", Send_out); end
    fall = -1; unstable = 1'b0;
    for (int c = k + 3; c <= k + 11; c++) begin
      wait_to(c);
      if (cur_out() !== e) unstable = 1'b1;
      if (fall < 0 && !Send_out) fall = c;
      if (c == k + 10) begin
        n_cmp++;
        if (BUSY !== 1'b1) begin n_err++; $display("FAIL store_rel_busy: BUSY=%b expected 1", BUSY); end
      end
    end
    n_cmp++;
    if (fall != k + 8) begin n_err++; $display("FAIL store_fall: Send_out fell at k+%0d expected k+8", fall - k); end
    n_cmp++;
    if (unstable) begin n_err++; $display("FAIL store_stable: outputs changed, expected %h", e); end
    n_cmp++;
    if (BUSY !== 1'b0) begin n_err++; $display("FAIL store_idle: BUSY=%b at k+11 expected 0", BUSY); end
    n_cmp++;
    if (got_q.size() != 1 || got_q[0].cyc != k + 2) begin
      n_err++; $display("FAIL store_once: %0d requests expected 1 at k+2", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    matx_entry_t exp[6]; bit acc; int k;
    do_reset();
    auto_ack = 1'b1; ack_delay = 0;
    for (int i = 0; i < 6; i++) begin
      exp[i] = rnd_entry(); exp[i].packet[9:0] = 10'(i); exp[i].load_flg = 1'b1; exp[i].write_en = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      push(exp[i], acc);
      if (i == 0) k = cyc;
      n_cmp++;
      if (acc !== (i < 5)) begin n_err++; $display("FAIL b2b_accept%0d: accepted=%b expected %b", i, acc, (i < 5)); end
      if (i == 4) begin
        n_cmp++;
        if (IN_READY !== 1'b0 || COUNT !== 3'd4) begin
          n_err++; $display("FAIL b2b_full: rdy=%b cnt=%0d expected 0/4", IN_READY, COUNT);
        end
      end
    end
    wait_got(5, 100, "b2b_deliver");
    wait_idle(50, "b2b_idle");
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].e !== exp[i]) begin n_err++; $display("FAIL b2b_data%0d: got %h expected %h", i, got_q[i].e, exp[i]); end
      n_cmp++;
      if (got_q[i].cyc != k + 2 + 8 * i) begin
        n_err++; $display("FAIL b2b_time%0d: request at k+%0d expected k+%0d", i, got_q[i].cyc - k, 2 + 8 * i);
      end
    end
    n_cmp++;
    if (got_q.size() != 5) begin n_err++; $display("FAIL b2b_count: %0d deliveries expected 5", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_concurrent();
    matx_entry_t exp[$]; matx_entry_t e; bit acc; int k;
    do_reset();
    auto_ack = 1'b1; ack_delay = 0;
    for (int i = 0; i < 5; i++) begin
      e = rnd_entry(); push(e, acc); exp.push_back(e);
      if (i == 0) k = cyc;
    end
    wait_to(k + 8);
    e = rnd_entry(); push(e, acc);
    n_cmp++;
    if (acc !== 1'b0 || COUNT !== 3'd3) begin
      n_err++; $display("FAIL conc_full_pop: acc=%b cnt=%0d expected 0/3", acc, COUNT);
    end
    wait_to(k + 16);
    e = rnd_entry(); push(e, acc); exp.push_back(e);
    n_cmp++;
    if (acc !== 1'b1 || COUNT !== 3'd3) begin
      n_err++; $display("FAIL conc_push_pop: acc=%b cnt=%0d expected 1/3", acc, COUNT);
    end
    wait_got(6, 120, "conc_deliver");
    wait_idle(50, "conc_idle");
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].e !== exp[i]) begin n_err++; $display("FAIL conc_order%0d: got %h expected %h", i, got_q[i].e, exp[i]); end
    end
    got_q.delete();
  endtask

  task automatic test_early_ack();
    matx_entry_t e; bit acc; int k;
    do_reset();
    man_ack = 1'b1;
    wait_to(cyc + 3);
    n_cmp++;
    if (Send_out !== 1'b0 || BUSY !== 1'b0) begin n_err++; $display("FAIL early_idle: send=%b busy=%b expected 0/0", Send_out, BUSY); end
    e = rnd_entry(); push(e, acc); k = cyc;
    wait_to(k + 1);
    n_cmp++;
    if (Send_out !== 1'b0 || BUSY !== 1'b1) begin n_err++; $display("FAIL early_setup: send=%b busy=%b expected 0/1", Send_out, BUSY); end
    wait_to(k + 2);
    n_cmp++;
    if (Send_out !== 1'b1) begin n_err++; $display("FAIL early_req: Send_out=%b expected 1", Send_out); end
    wait_to(k + 3);
    n_cmp++;
    if (Send_out !== 1'b0 || BUSY !== 1'b1) begin n_err++; $display("FAIL early_rel: send=%b busy=%b expected 0/1", Send_out, BUSY); end
    man_ack = 1'b0;
    wait_to(k + 5);
    n_cmp++;
    if (BUSY !== 1'b1) begin n_err++; $display("FAIL early_hold: BUSY=%b at k+5 expected 1", BUSY); end
    wait_to(k + 6);
    n_cmp++;
    if (BUSY !== 1'b0 || got_q.size() != 1) begin
      n_err++; $display("FAIL early_done: busy=%b requests=%0d expected 0/1", BUSY, got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0].e !== e) begin n_err++; $display("FAIL early_data: got %h expected %h", got_q[0].e, e); end
    end
    got_q.delete();
  endtask

  task automatic test_random();
    matx_entry_t exp[$]; matx_entry_t e; bit acc; int t;
    got_q.delete();
    auto_ack = 1'b1; ack_delay = $urandom_range(0, 4);
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CP);
      e = rnd_entry(); acc = 1'b0; t = 0;
      while (!acc && t < 200) begin push(e, acc); t++; end
      n_cmp++;
      if (!acc) begin n_err++; $display("FAIL rnd_push%0d: not accepted within bound", i); end
      else exp.push_back(e);
    end
    wait_got(exp.size(), 2000, "rnd_deliver");
    wait_idle(100, "rnd_idle");
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].e !== exp[i]) begin n_err++; $display("FAIL rnd_data%0d: got %h expected %h", i, got_q[i].e, exp[i]); end
    end
    got_q.delete();
  endtask

  task automatic test_stall();
    matx_entry_t e; bit acc; int k, r;
    do_reset();
    n_cmp++;
    if (TIMEOUT_ERR !== 1'b0) begin n_err++; $display("FAIL stall_clear: TIMEOUT_ERR=%b expected 0", TIMEOUT_ERR); end
    e = rnd_entry(); push(e, acc); k = cyc; r = k + 2;
    wait_to(r);
    n_cmp++;
    if (Send_out !== 1'b1) begin n_err++; $display("FAIL stall_req: Send_out=%b expected 1", Send_out); end
    wait_to(r + 15);
    n_cmp++;
    if (TIMEOUT_ERR !== 1'b0 || Send_out !== 1'b1) begin
      n_err++; $display("FAIL stall_pre: err=%b send=%b expected 0/1", TIMEOUT_ERR, Send_out);
    end
    wait_to(r + 16);
    n_cmp++;
    if (TIMEOUT_ERR !== 1'b1 || Send_out !== 1'b1) begin
      n_err++; $display("FAIL stall_flag: err=%b send=%b expected 1/1", TIMEOUT_ERR, Send_out);
    end
    man_ack = 1'b1;
    wait_to(r + 18);
    n_cmp++;
    if (Send_out !== 1'b1) begin n_err++; $display("FAIL stall_sync: Send_out=%b expected 1", Send_out); end
    wait_to(r + 19);
    n_cmp++;
    if (Send_out !== 1'b0) begin n_err++; $display("FAIL stall_fall: Send_out=%b expected 0", Send_out); end
    man_ack = 1'b0;
    wait_to(r + 22);
    n_cmp++;
    if (BUSY !== 1'b0 || TIMEOUT_ERR !== 1'b1) begin
      n_err++; $display("FAIL stall_end: busy=%b err=%b expected 0/1", BUSY, TIMEOUT_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_back_to_back();
    test_concurrent();
    test_early_ack();
    test_random();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
